riscv_mc_core: RTL
==================

Name: riscv_mc_core

Overview:
- Parametrised multi-cycle RISC-V integer core. It is the successor of the single-cycle datapath.
- It adds:
  - XLEN generalisation (32/64)
  - req/ack handshakes on instruction and data memory, so it works with slow memories
  - an explicit state machine with instruction register
  - trap on illegal opcode
  - an optional iterative multiplier
- It sits between the external register file and the IMEM/DMEM wrappers of the SoC top.

Parameters:
- XLEN, 64, datapath width; legal values are 32 and 64.
- RESET_PC, 0, PC value loaded on reset. It is XLEN bits wide and must be 4-byte aligned.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, synchronous, active-low. rst=0 at a rising clk edge resets the block.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  XLEN  fetch address, equal to PC.
- imem_rdata  in  32  instruction; sampled in the imem_ack cycle.
- imem_ack  in  1  fetch complete.
- dmem_req  out  1  data request; held high until dmem_ack.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  XLEN  rs1 + sign-extended immediate.
- dmem_wdata  out  XLEN  rs2 value.
- dmem_rdata  in  XLEN  load data; sampled in the dmem_ack cycle.
- dmem_ack  in  1  data transfer complete.
- readAddr1_RF  out  5  IR[19:15].
- readAddr2_RF  out  5  IR[24:20].
- readData1_RF  in  XLEN  asynchronous rs1 data.
- readData2_RF  in  XLEN  asynchronous rs2 data.
- writeAddr_RF  out  5  IR[11:7].
- writeData_RF  out  XLEN  writeback data.
- RegWrite_RF  out  1  one-cycle write strobe.
- retire  out  1  one-cycle pulse per completed instruction.
- trap  out  1  sticky illegal-instruction flag.

Behaviour:
- Supported instructions:
  - LUI, AUIPC, JAL, JALR
  - BEQ, BNE, BLT, BGE, BLTU, BGEU
  - ADDI, ANDI, ORI, XORI, SLTI
  - ADD, SUB, AND, OR, XOR, SLT
  - Load/store of width XLEN: LD/SD when XLEN=64, LW/SW when XLEN=32.
  - MUL only with the optional feature.
  - Any other opcode/funct combination is illegal.
- Reset (rst=0 at a clk edge):
  - PC=RESET_PC, IR=0, state=FETCH.
  - All outputs are 0, including trap.
  - Any outstanding imem/dmem request is abandoned: req is low in the cycle after reset. Acks that arrive during reset or after it are ignored.
- FETCH state:
  - imem_req=1 and imem_addr=PC.
  - On imem_ack: IR<=imem_rdata, go to EXEC.
  - imem_req stays asserted, address stable, until ack.
- EXEC state (exactly one cycle):
  - Decode IR; RF reads are combinational.
  - ALU ops, LUI, AUIPC, JAL, JALR:
    - RegWrite_RF=1 in this cycle.
    - PC updates at the end of the cycle.
    - retire=1; go to FETCH.
  - Branches:
    - Taken: PC<=PC+immB. Not taken: PC<=PC+4.
    - Comparisons are signed for BLT/BGE and unsigned for BLTU/BGEU.
    - retire=1; no RF write.
  - JALR: PC<=(rs1+immI) with bit0 cleared; rd<=PC+4.
  - Load/store: go to MEM.
  - Illegal instruction: go to TRAP. No write, no retire.
- MEM state:
  - dmem_req=1 and dmem_we=store.
  - Address and data are held stable until dmem_ack.
  - On ack:
    - Load: RegWrite_RF=1 with writeData_RF=dmem_rdata.
    - Both: retire=1, PC<=PC+4, go to FETCH.
- TRAP state:
  - trap=1; no requests issued.
  - The block stays in TRAP until reset.
- Writeback to rd=0: RegWrite_RF is forced to 0; retire still pulses.
- Arithmetic:
  - All arithmetic is modulo 2^XLEN.
  - Immediates are sign-extended to XLEN.
  - PC arithmetic wraps at 2^XLEN.
- Ack arriving in a state that is not waiting for it: ignored.
- Minimum latency:
  - ALU/branch: 2 cycles (FETCH with same-cycle ack, then EXEC).
  - Load/store: 3 cycles.

Optional Feature:
- Macro: RISCV_MC_MUL_EN.
- Defined:
  - MUL (funct7=0000001, funct3=000) is legal.
  - EXEC goes to MULT state, an iterative shift-add multiplier taking 1 bit per cycle, XLEN cycles in total.
  - On the last cycle: RegWrite_RF=1 with the low XLEN bits of the product, retire=1, PC<=PC+4, go to FETCH.
  - rs1/rs2 are latched on entry to MULT.
- Undefined: MUL is illegal and goes to TRAP.

Test Plan:
- Reset with RESET_PC=0x100, then release: imem_req=1 with imem_addr=0x100 in the first cycle. Hold ack off for 5 cycles: req and address stay stable.
- ADDI x5,x0,-3 (0xFFD00293), XLEN=64, same-cycle ack: in EXEC, RegWrite_RF=1, writeAddr_RF=5, writeData_RF=0xFFFFFFFFFFFFFFFD, retire=1; next fetch at PC+4.
- BLTU x1,x2,+16 with x1=1, x2=0xFFFF_FFFF_FFFF_FFFF: taken, next imem_addr=PC+16. BLT with the same operands: not taken, next address PC+4.
- SD then LD at address 0x40, dmem_ack delayed 3 cycles: dmem_req held 4 cycles with dmem_addr=0x40. The load writes back dmem_rdata in its ack cycle.
- Word 0xFFFFFFFF fetched: trap=1 and stays high, no further imem_req. Then rst=0 for one edge: trap=0 and a fetch from RESET_PC.
- RISCV_MC_MUL_EN, XLEN=32, MUL x3=7*(-6): after 32 MULT cycles, writeData_RF=0xFFFFFFD6. Without the macro, the same instruction raises trap.

Source files
------------

// File: rtl/riscv_mc_core.sv
// rtl/riscv_mc_core.sv - multi-cycle RISC-V integer core with req/ack memories, optional MUL (RISCV_MC_MUL_EN)
module riscv_mc_core #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ack,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output logic [4:0]      readAddr1_RF,
    output logic [4:0]      readAddr2_RF,
    input  logic [XLEN-1:0] readData1_RF,
    input  logic [XLEN-1:0] readData2_RF,
    output logic [4:0]      writeAddr_RF,
    output logic [XLEN-1:0] writeData_RF,
    output logic            RegWrite_RF,
    output logic            retire,
    output logic            trap
);
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
    localparam logic [2:0] LS_F3 = (XLEN == 64) ? 3'b011 : 3'b010;

    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_MULT, S_TRAP} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1, rs2, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] pc_plus4, jalr_t, alu_b, alu_res, exec_wd, pc_next;
    logic            legal, is_mem, is_mul, do_wr, take, alu_f3_ok, alu_sub, is_store;

    assign opcode   = ir_q[6:0];
    assign rd       = ir_q[11:7];
    assign funct3   = ir_q[14:12];
    assign funct7   = ir_q[31:25];
    assign rs1      = readData1_RF;
    assign rs2      = readData2_RF;
    assign imm_i    = XLEN'($signed(ir_q[31:20]));
    assign imm_s    = XLEN'($signed({ir_q[31:25], ir_q[11:7]}));
    assign imm_b    = XLEN'($signed({ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0}));
    assign imm_u    = XLEN'($signed({ir_q[31:12], 12'b0}));
    assign imm_j    = XLEN'($signed({ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0}));
    assign pc_plus4 = pc_q + XLEN'(4);
    assign jalr_t   = rs1 + imm_i;
    assign is_store = (opcode == OP_STORE);
    assign alu_sub  = (opcode == OP_REG) && funct7[5];
    assign alu_b    = (opcode == OP_REG) ? rs2 : imm_i;
    assign alu_f3_ok = funct3 inside {3'b000, 3'b111, 3'b110, 3'b100, 3'b010};

    always_comb begin
        alu_res = '0;
        case (funct3)
            3'b000:  alu_res = alu_sub ? rs1 - alu_b : rs1 + alu_b;
            3'b111:  alu_res = rs1 & alu_b;
            3'b110:  alu_res = rs1 | alu_b;
            3'b100:  alu_res = rs1 ^ alu_b;
            3'b010:  alu_res = XLEN'($signed(rs1) < $signed(alu_b));
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        take = 1'b0;
        case (funct3)
            3'b000:  take = (rs1 == rs2);
            3'b001:  take = (rs1 != rs2);
            3'b100:  take = ($signed(rs1) < $signed(rs2));
            3'b101:  take = !($signed(rs1) < $signed(rs2));
            3'b110:  take = (rs1 < rs2);
            3'b111:  take = !(rs1 < rs2);
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        legal   = 1'b0;
        is_mem  = 1'b0;
        is_mul  = 1'b0;
        do_wr   = 1'b0;
        exec_wd = pc_plus4;
        pc_next = pc_plus4;
        case (opcode)
            OP_LUI:   begin legal = 1'b1; do_wr = 1'b1; exec_wd = imm_u; end
            OP_AUIPC: begin legal = 1'b1; do_wr = 1'b1; exec_wd = pc_q + imm_u; end
            OP_JAL:   begin legal = 1'b1; do_wr = 1'b1; pc_next = pc_q + imm_j; end
            OP_JALR: begin
                legal   = (funct3 == 3'b000);
                do_wr   = legal;
                pc_next = {jalr_t[XLEN-1:1], 1'b0};
            end
            OP_BRANCH: begin
                legal = (funct3 != 3'b010) && (funct3 != 3'b011);
                if (take) pc_next = pc_q + imm_b;
            end
            OP_IMM: begin legal = alu_f3_ok; do_wr = legal; exec_wd = alu_res; end
            OP_REG: begin
                legal = ((funct7 == 7'b0000000) && alu_f3_ok) ||
                        ((funct7 == 7'b0100000) && (funct3 == 3'b000));
`ifdef RISCV_MC_MUL_EN
                if ((funct7 == 7'b0000001) && (funct3 == 3'b000)) begin
                    legal  = 1'b1;
                    is_mul = 1'b1;
                end
`endif
                do_wr   = legal;
                exec_wd = alu_res;
            end
            OP_LOAD, OP_STORE: begin legal = (funct3 == LS_F3); is_mem = 1'b1; end
            default: legal = 1'b0;
        endcase
    end

`ifdef RISCV_MC_MUL_EN
    localparam int CW = $clog2(XLEN);
    logic [XLEN-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
`endif

    logic            req_i_c, req_d_c, we_c, wr_c, retire_c, trap_c;
    logic [XLEN-1:0] wd_c;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        req_i_c  = 1'b0;
        req_d_c  = 1'b0;
        we_c     = 1'b0;
        wr_c     = 1'b0;
        wd_c     = exec_wd;
        retire_c = 1'b0;
        trap_c   = 1'b0;
`ifdef RISCV_MC_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_FETCH: begin
                req_i_c = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!legal) begin
                    state_d = S_TRAP;
                end else if (is_mem) begin
                    state_d = S_MEM;
                end else if (is_mul) begin
`ifdef RISCV_MC_MUL_EN
                    mcand_d  = rs1;
                    mplier_d = rs2;
                    acc_d    = '0;
                    cnt_d    = '0;
`endif
                    state_d  = S_MULT;
                end else begin
                    wr_c     = do_wr;
                    retire_c = 1'b1;
                    pc_d     = pc_next;
                    state_d  = S_FETCH;
                end
            end
            S_MEM: begin
                req_d_c = 1'b1;
                we_c    = is_store;
                if (dmem_ack) begin
                    wr_c     = !is_store;
                    wd_c     = dmem_rdata;
                    retire_c = 1'b1;
                    pc_d     = pc_plus4;
                    state_d  = S_FETCH;
                end
            end
`ifdef RISCV_MC_MUL_EN
            // One multiplier bit per cycle; the final partial sum is written back directly.
            S_MULT: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN - 1)) begin
                    wr_c     = 1'b1;
                    wd_c     = acc_d;
                    retire_c = 1'b1;
                    pc_d     = pc_plus4;
                    state_d  = S_FETCH;
                end
            end
`endif
            S_TRAP:  trap_c = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end

    // Every output is forced low while reset is asserted.
    always_comb begin
        imem_req     = rst & req_i_c;
        imem_addr    = rst ? pc_q : '0;
        dmem_req     = rst & req_d_c;
        dmem_we      = rst & we_c;
        dmem_addr    = rst ? rs1 + (is_store ? imm_s : imm_i) : '0;
        dmem_wdata   = rst ? rs2 : '0;
        readAddr1_RF = rst ? ir_q[19:15] : 5'd0;
        readAddr2_RF = rst ? ir_q[24:20] : 5'd0;
        writeAddr_RF = rst ? rd : 5'd0;
        writeData_RF = rst ? wd_c : '0;
        RegWrite_RF  = rst & wr_c & (rd != 5'd0);
        retire       = rst & retire_c;
        trap         = rst & trap_c;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

`ifdef RISCV_MC_MUL_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end
`endif
endmodule
